// File: rtl/stoch_pkg.sv
// ----------------------------------------------------------------------------
// stoch_pkg
// Shared helpers for the stochastic datapath blocks.
//   clog2             : constant ceil(log2(value)), for deriving widths
//   counter_width_ok  : legality check for a signed residue counter that
//                       must absorb a per-cycle delta of +/-n_inputs
// ----------------------------------------------------------------------------
package stoch_pkg;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // The counter needs the delta width plus one bit of headroom so that
   // c + d never wraps before saturation is applied.
   function automatic bit counter_width_ok(input int n_inputs, input int counter_size);
      return counter_size >= clog2(n_inputs + 1) + 2;
   endfunction

endpackage

// File: rtl/stoch_lane_popdiff.sv
// ----------------------------------------------------------------------------
// stoch_lane_popdiff
// Combinational per-lane routing and population difference.
//   a_p, a_m  : plus/minus channel bit of each lane
//   sub_mask  : 1 = lane is subtracted (its p/m channels swap roles)
//   d         : signed sum(pos) - sum(neg), range [-N_INPUTS, +N_INPUTS]
// ----------------------------------------------------------------------------
module stoch_lane_popdiff
   import stoch_pkg::*;
#(
   parameter int N_INPUTS = 4,
   parameter int D_WIDTH  = clog2(N_INPUTS + 1) + 1
) (
   input  logic [N_INPUTS-1:0]       a_p,
   input  logic [N_INPUTS-1:0]       a_m,
   input  logic [N_INPUTS-1:0]       sub_mask,
   output logic signed [D_WIDTH-1:0] d
);

   localparam int CW = D_WIDTH - 1;

   logic [N_INPUTS-1:0] pos;
   logic [N_INPUTS-1:0] neg;
   logic [CW-1:0]       pos_cnt;
   logic [CW-1:0]       neg_cnt;

   // Subtracting a signed-channel value is just swapping its channels.
   assign pos = (a_p & ~sub_mask) | (a_m & sub_mask);
   assign neg = (a_m & ~sub_mask) | (a_p & sub_mask);

   always_comb begin
      pos_cnt = '0;
      neg_cnt = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
         pos_cnt = pos_cnt + CW'(pos[i]);
         neg_cnt = neg_cnt + CW'(neg[i]);
      end
   end

   // Counts are at most N_INPUTS < 2^CW, so one extra sign bit is enough.
   assign d = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});

endmodule

// File: rtl/stoch_signed_nsum.sv
// ----------------------------------------------------------------------------
// stoch_signed_nsum
// N-input signed-channel stochastic adder/subtractor built around a single
// saturating signed residue counter. Opposing p/m pulses cancel inside the
// counter; at most one output pulse (on y_p or y_m) is emitted per cycle and
// any remaining residue drains over later cycles.
//   CLK       : clock, rising edge
//   nRST      : synchronous active-low reset
//   a_p, a_m  : per-lane plus/minus channel bits
//   sub_mask  : per-lane mode, 1 = subtract
//   y_p, y_m  : registered output pulses, never both 1
//   sat_flag  : sticky "counter clamped" flag, only when the macro
//               STOCH_NSUM_SAT_FLAG_EN is defined
// ----------------------------------------------------------------------------
module stoch_signed_nsum
   import stoch_pkg::*;
#(
   parameter int N_INPUTS     = 4,
   parameter int COUNTER_SIZE = 8
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic [N_INPUTS-1:0] a_p,
   input  logic [N_INPUTS-1:0] a_m,
   input  logic [N_INPUTS-1:0] sub_mask,
   output logic                y_p,
   output logic                y_m
`ifdef STOCH_NSUM_SAT_FLAG_EN
   ,
   output logic                sat_flag
`endif
);

   localparam int DW = clog2(N_INPUTS + 1) + 1;
   localparam int TW = COUNTER_SIZE + 1;

   localparam logic signed [TW-1:0] C_MAX = {2'b00, {(COUNTER_SIZE-1){1'b1}}};
   localparam logic signed [TW-1:0] C_MIN = {2'b11, {(COUNTER_SIZE-1){1'b0}}};
   localparam logic signed [TW-1:0] ONE   = {{(TW-1){1'b0}}, 1'b1};

   if (N_INPUTS < 2) begin : g_bad_inputs
      $error("stoch_signed_nsum: N_INPUTS must be >= 2");
   end
   if (!counter_width_ok(N_INPUTS, COUNTER_SIZE)) begin : g_bad_width
      $error("stoch_signed_nsum: COUNTER_SIZE too small for N_INPUTS");
   end

   logic signed [DW-1:0]           d;
   logic signed [COUNTER_SIZE-1:0] c;
   logic signed [COUNTER_SIZE-1:0] c_next;
   logic signed [TW-1:0]           t;
   logic signed [TW-1:0]           t_step;
   logic                           yp_next;
   logic                           ym_next;
   logic                           sat_hi;
   logic                           sat_lo;

   stoch_lane_popdiff #(
      .N_INPUTS (N_INPUTS),
      .D_WIDTH  (DW)
   ) u_popdiff (
      .a_p      (a_p),
      .a_m      (a_m),
      .sub_mask (sub_mask),
      .d        (d)
   );

   always_comb begin
      // One guard bit so c + d cannot wrap before clamping.
      t       = {c[COUNTER_SIZE-1], c} + {{(TW-DW){d[DW-1]}}, d};
      yp_next = 1'b0;
      ym_next = 1'b0;
      t_step  = '0;
      if (t[TW-1]) begin
         ym_next = 1'b1;
         t_step  = t + ONE;
      end else if (|t) begin
         yp_next = 1'b1;
         t_step  = t - ONE;
      end
      sat_hi = (t_step > C_MAX);
      sat_lo = (t_step < C_MIN);
      if (sat_hi)      c_next = C_MAX[COUNTER_SIZE-1:0];
      else if (sat_lo) c_next = C_MIN[COUNTER_SIZE-1:0];
      else             c_next = t_step[COUNTER_SIZE-1:0];
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         c   <= '0;
         y_p <= 1'b0;
         y_m <= 1'b0;
      end else begin
         c   <= c_next;
         y_p <= yp_next;
         y_m <= ym_next;
      end
   end

`ifdef STOCH_NSUM_SAT_FLAG_EN
   always_ff @(posedge CLK) begin
      if (!nRST)                sat_flag <= 1'b0;
      else if (sat_hi | sat_lo) sat_flag <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_stoch_signed_nsum.sv
module tb_stoch_signed_nsum;

   localparam int N  = 4;
   localparam int CS = 8;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic [N-1:0] a_p = '0;
   logic [N-1:0] a_m = '0;
   logic [N-1:0] sub_mask = '0;
   logic         y_p;
   logic         y_m;
`ifdef STOCH_NSUM_SAT_FLAG_EN
   logic         sat_flag;
   logic         m_sat = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int m_c = 0;
   logic [1:0] sb[$];

   always #5 clk = ~clk;

   stoch_signed_nsum #(.N_INPUTS(N), .COUNTER_SIZE(CS)) dut (
      .CLK      (clk),
      .nRST     (nrst),
      .a_p      (a_p),
      .a_m      (a_m),
      .sub_mask (sub_mask),
      .y_p      (y_p),
      .y_m      (y_m)
`ifdef STOCH_NSUM_SAT_FLAG_EN
      ,
      .sat_flag (sat_flag)
`endif
   );

   // Drive one cycle of stimulus, advance the reference model and push the
   // expected {y_p, y_m}; returns #1 after the edge that registers it.
   task automatic step(input logic rst_n, input logic [N-1:0] ap,
                       input logic [N-1:0] am, input logic [N-1:0] sm);
      int d, t, cn;
      logic [1:0] e;
      @(negedge clk);
      nrst = rst_n; a_p = ap; a_m = am; sub_mask = sm;
      if (!rst_n) begin
         m_c = 0;
         e   = 2'b00;
`ifdef STOCH_NSUM_SAT_FLAG_EN
         m_sat = 1'b0;
`endif
      end else begin
         d = 0;
         for (int i = 0; i < N; i++) begin
            if (sm[i]) d += int'(am[i]) - int'(ap[i]);
            else       d += int'(ap[i]) - int'(am[i]);
         end
         t = m_c + d;
         if (t >= 1)       begin e = 2'b10; cn = t - 1; end
         else if (t <= -1) begin e = 2'b01; cn = t + 1; end
         else              begin e = 2'b00; cn = 0;     end
         if (cn > 127) begin
            cn = 127;
`ifdef STOCH_NSUM_SAT_FLAG_EN
            m_sat = 1'b1;
`endif
         end
         if (cn < -128) begin
            cn = -128;
`ifdef STOCH_NSUM_SAT_FLAG_EN
            m_sat = 1'b1;
`endif
         end
         m_c = cn;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [1:0] e;
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 4'hF, 4'hF, 4'hF);
         e = sb.pop_front();
         checks++;
         if ({y_p, y_m} !== e) begin
            errors++;
            $display("FAIL reset cyc %0d got %b exp %b", k, {y_p, y_m}, e);
         end
`ifdef STOCH_NSUM_SAT_FLAG_EN
         checks++;
         if (sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_sat got %b exp 0", sat_flag);
         end
`endif
      end
      step(1'b1, 4'h0, 4'h0, 4'h0);
      e = sb.pop_front();
      checks++;
      if ({y_p, y_m} !== 2'b00 || e !== 2'b00) begin
         errors++;
         $display("FAIL reset_idle got %b exp 00", {y_p, y_m});
      end
   endtask

   task automatic test_single_add();
      logic [1:0] e;
      for (int k = 0; k < 20; k++) begin
         step(1'b1, 4'b0001, 4'b0000, 4'b0000);
         e = sb.pop_front();
         checks++;
         if ({y_p, y_m} !== e) begin
            errors++;
            $display("FAIL single_add cyc %0d got %b exp %b", k, {y_p, y_m}, e);
         end
      end
   endtask

   task automatic test_cancel();
      logic [1:0] e;
      step(1'b0, 4'h0, 4'h0, 4'h0);
      void'(sb.pop_front());
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 4'b0011, 4'b0000, 4'b0010);
         e = sb.pop_front();
         checks++;
         if ({y_p, y_m} !== e || e !== 2'b00) begin
            errors++;
            $display("FAIL cancel cyc %0d got %b exp 00", k, {y_p, y_m});
         end
      end
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 4'b0011, 4'b0000, 4'b0000);
         e = sb.pop_front();
         checks++;
         if ({y_p, y_m} !== e) begin
            errors++;
            $display("FAIL cancel_add cyc %0d got %b exp %b", k, {y_p, y_m}, e);
         end
      end
   endtask

   task automatic test_drain();
      logic [1:0] e;
      int pulses;
      step(1'b0, 4'h0, 4'h0, 4'h0);
      void'(sb.pop_front());
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 4'b1111, 4'b0000, 4'b0000);
         e = sb.pop_front();
         checks++;
         if ({y_p, y_m} !== e) begin
            errors++;
            $display("FAIL drain_fill cyc %0d got %b exp %b", k, {y_p, y_m}, e);
         end
      end
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         step(1'b1, 4'h0, 4'h0, 4'h0);
         e = sb.pop_front();
         if (y_p === 1'b1) pulses++;
         checks++;
         if ({y_p, y_m} !== e) begin
            errors++;
            $display("FAIL drain cyc %0d got %b exp %b", k, {y_p, y_m}, e);
         end
      end
      checks++;
      if (pulses != 30) begin
         errors++;
         $display("FAIL drain_count got %0d exp 30", pulses);
      end
   endtask

   task automatic test_saturation();
      logic [1:0] e;
      int pulses;
      step(1'b0, 4'h0, 4'h0, 4'h0);
      void'(sb.pop_front());
      pulses = 0;
      for (int k = 0; k < 100; k++) begin
         step(1'b1, 4'b0000, 4'b1111, 4'b0000);
         e = sb.pop_front();
         if (y_m === 1'b1) pulses++;
         checks++;
         if ({y_p, y_m} !== e) begin
            errors++;
            $display("FAIL sat_fill cyc %0d got %b exp %b", k, {y_p, y_m}, e);
         end
      end
      checks++;
      if (pulses != 100) begin
         errors++;
         $display("FAIL sat_fill_count got %0d exp 100", pulses);
      end
`ifdef STOCH_NSUM_SAT_FLAG_EN
      checks++;
      if (sat_flag !== 1'b1 || m_sat !== 1'b1) begin
         errors++;
         $display("FAIL sat_flag got %b exp 1", sat_flag);
      end
`endif
      pulses = 0;
      for (int k = 0; k < 140; k++) begin
         step(1'b1, 4'h0, 4'h0, 4'h0);
         e = sb.pop_front();
         if (y_m === 1'b1) pulses++;
         checks++;
         if ({y_p, y_m} !== e) begin
            errors++;
            $display("FAIL sat_drain cyc %0d got %b exp %b", k, {y_p, y_m}, e);
         end
      end
      checks++;
      if (pulses != 128) begin
         errors++;
         $display("FAIL sat_drain_count got %0d exp 128", pulses);
      end
   endtask

   task automatic test_mid_reset();
      logic [1:0] e;
      step(1'b0, 4'h0, 4'h0, 4'h0);
      void'(sb.pop_front());
      // 16 cycles of +3 then 2 cycles of +1 leave c = 50.
      for (int k = 0; k < 18; k++) begin
         if (k < 16) step(1'b1, 4'b1111, 4'b0000, 4'b0000);
         else        step(1'b1, 4'b0011, 4'b0000, 4'b0000);
         e = sb.pop_front();
         checks++;
         if ({y_p, y_m} !== e) begin
            errors++;
            $display("FAIL mid_fill cyc %0d got %b exp %b", k, {y_p, y_m}, e);
         end
      end
      step(1'b0, 4'b1111, 4'b0000, 4'b0000);
      e = sb.pop_front();
      checks++;
      if ({y_p, y_m} !== e) begin
         errors++;
         $display("FAIL mid_reset got %b exp %b", {y_p, y_m}, e);
      end
`ifdef STOCH_NSUM_SAT_FLAG_EN
      checks++;
      if (sat_flag !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_sat got %b exp 0", sat_flag);
      end
`endif
      // Residue must be gone: idle inputs give idle outputs.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 4'h0, 4'h0, 4'h0);
         e = sb.pop_front();
         checks++;
         if ({y_p, y_m} !== 2'b00 || e !== 2'b00) begin
            errors++;
            $display("FAIL mid_after cyc %0d got %b exp 00", k, {y_p, y_m});
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] e;
      logic [N-1:0] ap, am, sm;
      step(1'b0, 4'h0, 4'h0, 4'h0);
      void'(sb.pop_front());
      for (int k = 0; k < 300; k++) begin
         ap = N'($urandom);
         am = N'($urandom);
         sm = N'($urandom);
         step(($urandom_range(0, 99) != 0), ap, am, sm);
         e = sb.pop_front();
         checks++;
         if ({y_p, y_m} !== e) begin
            errors++;
            $display("FAIL random cyc %0d ap %b am %b sm %b got %b exp %b",
                     k, ap, am, sm, {y_p, y_m}, e);
         end
`ifdef STOCH_NSUM_SAT_FLAG_EN
         checks++;
         if (sat_flag !== m_sat) begin
            errors++;
            $display("FAIL random_sat cyc %0d got %b exp %b", k, sat_flag, m_sat);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_cancel();
      test_drain();
      test_saturation();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stoch_signed_nsum.md
Name: stoch_signed_nsum

Overview:
- N-input signed-channel stochastic adder/subtractor. Each input lane carries a (p, m) bitstream pair; a per-lane mode bit selects whether the lane is added or subtracted.
- Output is one signed-channel stream (y_p, y_m) equal to the saturated sum of the lane values, with value = P(y_p) - P(y_m).
- A single shared signed residue counter replaces trees of pairwise saturating adders and subtractors. It cancels opposing p/m pulses inside the counter rather than across separate channels.
- Sits in the stochastic datapath wherever matrix and vector reductions need signed multi-operand sums.

Parameters:
- N_INPUTS, 4, number of signed input lanes (>= 2).
- COUNTER_SIZE, 8, width of the signed residue counter in bits. Must be >= clog2(N_INPUTS+1)+2.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
- a_p  input  N_INPUTS  plus-channel bit of each lane.
- a_m  input  N_INPUTS  minus-channel bit of each lane.
- sub_mask  input  N_INPUTS  mode per lane: 1 = subtract the lane, 0 = add it. Sampled every cycle.
- y_p  output  1  plus-channel output bit, registered.
- y_m  output  1  minus-channel output bit, registered.

Behaviour:
- Per-lane routing (combinational):
  - Add lane: pos_i = a_p[i], neg_i = a_m[i].
  - Subtract lane: pos_i = a_m[i], neg_i = a_p[i].
- Per-cycle delta: d = sum(pos_i) - sum(neg_i), signed, range [-N_INPUTS, +N_INPUTS].
- Residue counter c: signed, COUNTER_SIZE bits, reset value 0.
- Each edge with nRST=1, compute t = c + d in width COUNTER_SIZE+1 (no intermediate overflow), then:
  - t >= 1: y_p<=1, y_m<=0, c_next = t-1.
  - t <= -1: y_p<=0, y_m<=1, c_next = t+1.
  - t == 0: y_p<=0, y_m<=0, c_next = 0.
- c_next saturates to [-2^(COUNTER_SIZE-1), 2^(COUNTER_SIZE-1)-1]. Excess input mass beyond the counter range is discarded.
- y_p and y_m are never 1 in the same cycle.
- Latency: an input sample affects the outputs on the following edge (1 cycle).
- Output rate is at most one pulse per cycle. The output therefore saturates at +1 or -1, and residue beyond that drains over later cycles.
- Reset: nRST=0 at an edge sets c=0, y_p=0, y_m=0, regardless of inputs. This applies mid-operation too; residue is lost and there are no partial updates.
- A sub_mask change takes effect in the same cycle it is sampled. No pipeline flush is required.
- Equal positive and negative pulses in one cycle cancel (d=0); c is unchanged and both outputs are 0 only if c==0.

Optional Feature:
- Macro: STOCH_NSUM_SAT_FLAG_EN.
- Defined:
  - Adds output port sat_flag (1 bit, registered, reset 0).
  - sat_flag is set sticky on any edge where c_next was clamped in either direction.
  - Cleared only by nRST=0.
- Undefined:
  - Port absent, no flag logic.
  - Saturation behaviour is otherwise identical.

Decomposition:
- Shared package stoch_pkg holds:
  - the clog2 constant function;
  - the minimum-counter-width check function, used for a parameter-legality error at elaboration.
- Sub-module stoch_lane_popdiff (combinational) takes a_p, a_m and sub_mask and produces signed d, width clog2(N_INPUTS+1)+1.
- The top level holds the counter, saturation, output registers and the optional flag.

Test Plan:
All scenarios use N_INPUTS=4, COUNTER_SIZE=8.
- Reset: all inputs 1, nRST=0 for 2 cycles -> y_p=0, y_m=0, c=0. One cycle after nRST=1 with all inputs 0 -> outputs remain 0.
- Single add lane: a_p=4'b0001, a_m=0, sub_mask=0 for 20 cycles -> y_p=1 on every cycle from cycle 1, y_m=0 throughout.
- Cancellation: a_p=4'b0011, sub_mask=4'b0010 -> d=0, y_p=y_m=0 throughout. Then set sub_mask=4'b0000 -> y_p=1 from the next edge, c grows by 1 per cycle.
- Residue drain: a_p=4'b1111, sub_mask=0 for 10 cycles (c=30), then all inputs 0 -> y_p=1 for exactly 30 more cycles, then 0.
- Saturation and negative path:
  - Step 1: a_m=4'b1111 for 100 cycles -> c clamps at -128, y_m=1 every cycle; sat_flag=1 if STOCH_NSUM_SAT_FLAG_EN is defined.
  - Step 2: inputs to 0 -> exactly 128 y_m pulses.
- Mid-operation reset: c=50 then nRST=0 for one cycle -> next cycle c=0, y_p=0, and sat_flag=0 if the macro is defined.
